// File: rtl/cell_pos_streamer_pkg.sv
// cell_pos_streamer_pkg: shared widths, depths and FSM state type for the cell position streamer
package cell_pos_streamer_pkg;
  localparam int DEF_DATA_WIDTH   = 96;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_PARTICLE_NUM = 220;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_RD_LATENCY   = 2;
  typedef enum logic [2:0] {S_IDLE, S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN, S_FIN} state_t;
endpackage

// File: rtl/cell_pos_rd_fifo.sv
// cell_pos_rd_fifo: small synchronous FIFO buffering returned {position, id} words, exposes occupancy
module cell_pos_rd_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_occ
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [PW:0]      r_occ;
  // Storage and pointers; push and pop may coincide, leaving occupancy unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (i_push) r_mem[r_wp] <= i_din;
      r_wp  <= r_wp + PW'(i_push);
      r_rp  <= r_rp + PW'(i_pop);
      r_occ <= r_occ + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  assign o_dout  = r_mem[r_rp];
  assign o_empty = r_occ == '0;
  assign o_occ   = r_occ;
endmodule

// File: rtl/cell_pos_streamer.sv
// cell_pos_streamer: reads a cell's particle count then streams every position word with backpressure
module cell_pos_streamer
  import cell_pos_streamer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int RD_LATENCY   = DEF_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last
);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = OW + 2;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  state_t                           r_state;
  logic                             r_busy, r_done, r_err, r_rden;
  logic [ADDR_WIDTH-1:0]            r_count, r_addr, r_next;
  logic [RD_LATENCY-1:0]            r_pipe;
  logic [ADDR_WIDTH-1:0]            r_id_pipe [RD_LATENCY];
  logic [OW-1:0]                    w_occ;
  logic [UW-1:0]                    w_used;
  logic                             w_empty, w_push, w_pop, w_issue, w_drained;
  logic [ADDR_WIDTH-1:0]            w_raw;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] w_dout;
  assign w_raw     = mem_q[ADDR_WIDTH-1:0];
  assign w_push    = r_pipe[RD_LATENCY-1] && (r_state == S_STREAM || r_state == S_DRAIN);
  assign w_pop     = out_valid && out_ready;
  assign w_issue   = r_state == S_STREAM && w_used < UW'(FIFO_DEPTH);
  assign w_drained = r_pipe == '0 && !r_rden && w_occ == OW'(w_pop);
  // Credits in use: committed reads plus FIFO entries not leaving this cycle
  always_comb begin
    w_used = UW'(w_occ) + UW'(r_rden) - UW'(w_pop);
    for (int i = 0; i < RD_LATENCY; i++) w_used = w_used + UW'(r_pipe[i]);
  end
  // Control FSM with registered memory-side and status outputs; tail of r_pipe marks returning data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rden  <= 1'b0;
      r_count <= '0;
      r_addr  <= '0;
      r_next  <= '0;
      r_pipe  <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | RD_LATENCY'(r_rden);
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state <= S_RD_CNT;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_rden  <= 1'b1;
            r_addr  <= '0;
          end
        S_RD_CNT: begin
          r_state <= S_WAIT_CNT;
          r_rden  <= 1'b0;
        end
        S_WAIT_CNT:
          if (r_pipe[RD_LATENCY-1]) begin
            r_count <= w_raw > MAX_CNT ? MAX_CNT : w_raw;
            r_err   <= w_raw > MAX_CNT;
            r_next  <= ADDR_WIDTH'(1);
            r_state <= w_raw == '0 ? S_FIN : S_STREAM;
            r_done  <= w_raw == '0;
            r_busy  <= w_raw != '0;
          end
        S_STREAM: begin
          r_rden <= w_issue;
          if (w_issue) begin
            r_addr  <= r_next;
            r_next  <= r_next + ADDR_WIDTH'(1);
            r_state <= r_next == r_count ? S_DRAIN : S_STREAM;
          end
        end
        S_DRAIN: begin
          r_rden <= 1'b0;
          if (w_drained) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  // Carry each read's address alongside its latency slot so it lands in the FIFO with its data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_id_pipe[i] <= '0;
    end else begin
      r_id_pipe[0] <= r_addr;
      for (int i = 1; i < RD_LATENCY; i++) r_id_pipe[i] <= r_id_pipe[i-1];
    end
  cell_pos_rd_fifo #(
    .WIDTH(DATA_WIDTH + ADDR_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_din  ({mem_q, r_id_pipe[RD_LATENCY-1]}),
    .i_pop  (w_pop),
    .o_dout (w_dout),
    .o_empty(w_empty),
    .o_occ  (w_occ)
  );
  assign out_valid      = !w_empty;
  assign out_pos        = w_dout[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
  assign out_id         = w_dout[ADDR_WIDTH-1:0];
  assign out_last       = out_valid && out_id == r_count;
  assign busy           = r_busy;
  assign done           = r_done;
  assign count_err      = r_err;
  assign particle_count = r_count;
  assign mem_address    = r_addr;
  assign mem_rden       = r_rden;
  assign mem_wren       = 1'b0;
endmodule
